// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI timing/test-pattern generator:
// pattern mode encodings and the colour-bar palette.
package hdmi_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID    = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_GRADIENT = 2'd3
  } mode_e;

  // Bar colours as {R,G,B} on/off masks; each set bit becomes a full-scale channel.
  localparam logic [2:0] BAR_WHITE   = 3'b111;
  localparam logic [2:0] BAR_YELLOW  = 3'b110;
  localparam logic [2:0] BAR_CYAN    = 3'b011;
  localparam logic [2:0] BAR_GREEN   = 3'b010;
  localparam logic [2:0] BAR_MAGENTA = 3'b101;
  localparam logic [2:0] BAR_RED     = 3'b100;
  localparam logic [2:0] BAR_BLUE    = 3'b001;
  localparam logic [2:0] BAR_BLACK   = 3'b000;

  function automatic logic [2:0] bar_mask(input logic [2:0] idx);
    logic [2:0] m;
    m = BAR_BLACK;
    case (idx)
      3'd0:    m = BAR_WHITE;
      3'd1:    m = BAR_YELLOW;
      3'd2:    m = BAR_CYAN;
      3'd3:    m = BAR_GREEN;
      3'd4:    m = BAR_MAGENTA;
      3'd5:    m = BAR_RED;
      3'd6:    m = BAR_BLUE;
      default: m = BAR_BLACK;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/hdmi_video_timing_gen_if.sv
// Video port between the timing generator (master) and the HDMI transmitter (slave).
// Stream semantics: no back-pressure; DE high qualifies RGB/X/Y on that cycle, and
// EN/MODE/SOLID_RGB are control inputs owned by the slave side.
interface hdmi_video_timing_gen_if #(
  parameter int COLOR_W = 8,
  parameter int X_W     = 10,
  parameter int Y_W     = 9
);
  logic                 EN;
  logic [1:0]           MODE;
  logic [3*COLOR_W-1:0] SOLID_RGB;
  logic                 DE;
  logic                 HSYNC;
  logic                 VSYNC;
  logic [COLOR_W-1:0]   RED;
  logic [COLOR_W-1:0]   GREEN;
  logic [COLOR_W-1:0]   BLUE;
  logic                 FRAME_START;
  logic [X_W-1:0]       X;
  logic [Y_W-1:0]       Y;

  modport master (
    input  EN, MODE, SOLID_RGB,
    output DE, HSYNC, VSYNC, RED, GREEN, BLUE, FRAME_START, X, Y
  );

  modport slave (
    output EN, MODE, SOLID_RGB,
    input  DE, HSYNC, VSYNC, RED, GREEN, BLUE, FRAME_START, X, Y
  );
endinterface

// File: rtl/hdmi_sync_counter.sv
// Horizontal/vertical position counters with region flags for one video frame.
// Counters sit at h=v=0 while held in reset or disabled.
module hdmi_sync_counter #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  output logic [HW-1:0] h_o,
  output logic [VW-1:0] v_o,
  output logic          h_active_o,
  output logic          v_active_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          frame_first_o,
  output logic          line_last_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [31:0]   h32, v32;

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Compare in 32 bits so region limits equal to 2**HW cannot truncate.
  assign h32 = 32'(h_q);
  assign v32 = 32'(v_q);

  assign h_o           = h_q;
  assign v_o           = v_q;
  assign h_active_o    = h32 < H_ACTIVE;
  assign v_active_o    = v32 < V_ACTIVE;
  assign hsync_o       = ((h32 >= H_ACTIVE + H_FP) && (h32 < H_ACTIVE + H_FP + H_SYNC)) ? HS_POL : ~HS_POL;
  assign vsync_o       = ((v32 >= V_ACTIVE + V_FP) && (v32 < V_ACTIVE + V_FP + V_SYNC)) ? VS_POL : ~VS_POL;
  assign frame_first_o = (h_q == '0) && (v_q == '0);
  assign line_last_o   = (h_q == H_LAST);

endmodule

// File: rtl/hdmi_video_timing_gen.sv
// Video timing and test-pattern generator for the HDMI transmitter's parallel RGB port.
// Pattern mode is captured at the first pixel of each frame so switching never tears.
module hdmi_video_timing_gen
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int COLOR_W    = 8,
  parameter int CHECK_LOG2 = 5
) (
  input  logic CLK_PX,
  input  logic RST,
  output logic HDMI_CLK,
  hdmi_video_timing_gen_if.master vid
);

  localparam int HW    = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW    = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int X_W   = $clog2(H_ACTIVE);
  localparam int Y_W   = $clog2(V_ACTIVE);
  localparam int RGB_W = 3 * COLOR_W;
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic h_active, v_active, hsync, vsync, frame_first, line_last;

  hdmi_sync_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .HW(HW), .VW(VW)
  ) u_sync (
    .clk_i        (CLK_PX),
    .rst_i        (RST),
    .en_i         (vid.EN),
    .h_o          (h),
    .v_o          (v),
    .h_active_o   (h_active),
    .v_active_o   (v_active),
    .hsync_o      (hsync),
    .vsync_o      (vsync),
    .frame_first_o(frame_first),
    .line_last_o  (line_last)
  );

  mode_e            mode_q, mode_eff;
  logic [RGB_W-1:0] solid_q, solid_eff;

  // The first pixel of a frame already uses the freshly sampled mode and colour.
  always_comb begin
    mode_eff  = frame_first ? mode_e'(vid.MODE) : mode_q;
    solid_eff = frame_first ? vid.SOLID_RGB : solid_q;
  end

  always_ff @(posedge CLK_PX) begin
    if (RST) begin
      mode_q  <= MODE_SOLID;
      solid_q <= '0;
    end else if (vid.EN && frame_first) begin
      mode_q  <= mode_eff;
      solid_q <= solid_eff;
    end
  end

  logic [BW-1:0] bar_px_q, bar_px_d;
  logic [2:0]    bar_idx_q, bar_idx_d;

  // Bar index tracks the current column by counting pixels per bar instead of dividing h.
  always_comb begin
    bar_px_d  = bar_px_q;
    bar_idx_d = bar_idx_q;
    if (line_last) begin
      bar_px_d  = '0;
      bar_idx_d = '0;
    end else if (h_active) begin
      if (bar_px_q == BAR_LAST) begin
        bar_px_d  = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_px_d = bar_px_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_PX) begin
    if (RST || !vid.EN) begin
      bar_px_q  <= '0;
      bar_idx_q <= '0;
    end else begin
      bar_px_q  <= bar_px_d;
      bar_idx_q <= bar_idx_d;
    end
  end

  logic               de_d;
  logic [X_W-1:0]     x_d;
  logic [Y_W-1:0]     y_d;
  logic [RGB_W-1:0]   rgb_d;
  logic [2:0]         mask;
  logic [COLOR_W-1:0] grad;

  assign de_d = h_active & v_active;
  assign x_d  = X_W'(h);
  assign y_d  = Y_W'(v);
  assign grad = COLOR_W'(x_d);

  always_comb begin
    rgb_d = '0;
    mask  = bar_mask(bar_idx_q);
    if (de_d) begin
      case (mode_eff)
        MODE_SOLID:    rgb_d = solid_eff;
        MODE_BARS:     rgb_d = {{COLOR_W{mask[2]}}, {COLOR_W{mask[1]}}, {COLOR_W{mask[0]}}};
        MODE_CHECKER:  rgb_d = {RGB_W{x_d[CHECK_LOG2] ^ y_d[CHECK_LOG2]}};
        MODE_GRADIENT: rgb_d = {grad, grad, grad};
        default:       rgb_d = '0;
      endcase
    end
  end

  logic             de_q, hs_q, vs_q, fs_q;
  logic [RGB_W-1:0] rgb_q;
  logic [X_W-1:0]   x_q;
  logic [Y_W-1:0]   y_q;

  always_ff @(posedge CLK_PX) begin
    if (RST || !vid.EN) begin
      de_q  <= 1'b0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      rgb_q <= '0;
      fs_q  <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      de_q  <= de_d;
      hs_q  <= hsync;
      vs_q  <= vsync;
      rgb_q <= rgb_d;
      fs_q  <= frame_first;
      x_q   <= de_d ? x_d : '0;
      y_q   <= de_d ? y_d : '0;
    end
  end

  assign HDMI_CLK        = ~CLK_PX;
  assign vid.DE          = de_q;
  assign vid.HSYNC       = hs_q;
  assign vid.VSYNC       = vs_q;
  assign vid.RED         = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign vid.GREEN       = rgb_q[2*COLOR_W-1:COLOR_W];
  assign vid.BLUE        = rgb_q[COLOR_W-1:0];
  assign vid.FRAME_START = fs_q;
  assign vid.X           = x_q;
  assign vid.Y           = y_q;

endmodule

// File: tb/tb_hdmi_video_timing_gen.sv
// Self-checking bench for hdmi_video_timing_gen on a 24x12 total / 16x8 active raster.
module tb_hdmi_video_timing_gen;

  localparam int EXP_W = 35; // {de, hs, vs, rgb[23:0], fs, x[3:0], y[2:0]}

  logic clk = 1'b0;
  logic rst;
  logic hdmi_clk;

  hdmi_video_timing_gen_if #(.COLOR_W(8), .X_W(4), .Y_W(3)) vid ();

  hdmi_video_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(8), .CHECK_LOG2(1)
  ) dut (
    .CLK_PX  (clk),
    .RST     (rst),
    .HDMI_CLK(hdmi_clk),
    .vid     (vid)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [EXP_W-1:0] exp_q[$];

  logic        rst_s, en_s;
  logic [1:0]  mode_s;
  logic [23:0] solid_s;

  int          m_h, m_v;
  logic [1:0]  m_mode;
  logic [23:0] m_solid;

  function automatic logic [23:0] bar_colour(input int idx);
    logic [23:0] c;
    c = 24'h000000;
    case (idx)
      0: c = 24'hFFFFFF;
      1: c = 24'hFFFF00;
      2: c = 24'h00FFFF;
      3: c = 24'h00FF00;
      4: c = 24'hFF00FF;
      5: c = 24'hFF0000;
      6: c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  // Drive one cycle of stimulus, push the model's expected output for the next edge.
  task automatic drive_cycle();
    logic [EXP_W-1:0] e;
    logic [23:0]      rgb;
    logic             de;
    logic [7:0]       g;
    @(negedge clk);
    rst           = rst_s;
    vid.EN        = en_s;
    vid.MODE      = mode_s;
    vid.SOLID_RGB = solid_s;
    if (rst_s || !en_s) begin
      e = {1'b0, 1'b1, 1'b1, 24'h0, 1'b0, 7'h0};
      m_h = 0;
      m_v = 0;
      if (rst_s) begin
        m_mode  = 2'd0;
        m_solid = 24'h0;
      end
    end else begin
      if (m_h == 0 && m_v == 0) begin
        m_mode  = mode_s;
        m_solid = solid_s;
      end
      de  = (m_h < 16) && (m_v < 8);
      rgb = 24'h0;
      g   = 8'(m_h);
      if (de) begin
        case (m_mode)
          2'd0: rgb = m_solid;
          2'd1: rgb = bar_colour(m_h / 2);
          2'd2: rgb = ((((m_h >> 1) ^ (m_v >> 1)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
          default: rgb = {g, g, g};
        endcase
      end
      e = {de, !(m_h >= 18 && m_h < 21), !(m_v >= 9 && m_v < 11), rgb,
           (m_h == 0 && m_v == 0), 4'(m_h), 3'(m_v)};
      if (m_h == 23) begin
        m_h = 0;
        m_v = (m_v == 11) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every output cycle is compared against the model expectation.
  always @(posedge clk) begin
    logic [EXP_W-1:0] e, o;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = {vid.DE, vid.HSYNC, vid.VSYNC, vid.RED, vid.GREEN, vid.BLUE, vid.FRAME_START, vid.X, vid.Y};
      if (!e[34]) begin
        e[6:0] = '0;
        o[6:0] = '0;
      end
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL scoreboard t=%0t got=%h exp=%h", $time, o, e);
      end
    end
  end

  task automatic run_to_frame_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      drive_cycle();
      if (vid.FRAME_START === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_s = 1'b1; en_s = 1'b1; mode_s = 2'd0; solid_s = 24'h0;
    drive_cycle();
    drive_cycle();
    checks++;
    if (vid.DE !== 1'b0) begin failures++; $display("FAIL reset_de got=%b exp=0", vid.DE); end
    checks++;
    if ({vid.HSYNC, vid.VSYNC} !== 2'b11) begin failures++; $display("FAIL reset_sync got=%b%b exp=11", vid.HSYNC, vid.VSYNC); end
    checks++;
    if ({vid.RED, vid.GREEN, vid.BLUE} !== 24'h0) begin failures++; $display("FAIL reset_rgb got=%h exp=000000", {vid.RED, vid.GREEN, vid.BLUE}); end
    checks++;
    if ({vid.FRAME_START, vid.X, vid.Y} !== 8'h0) begin failures++; $display("FAIL reset_fs_xy got=%b/%0d/%0d exp=0/0/0", vid.FRAME_START, vid.X, vid.Y); end
    checks++;
    if (hdmi_clk !== ~clk) begin failures++; $display("FAIL hdmi_clk got=%b exp=%b", hdmi_clk, ~clk); end
  endtask

  task automatic test_timing();
    bit ok;
    int since_fs, fs_cnt, de_run, de_lines, hs_run, since_de_fall;
    logic prev_de, prev_hs;
    rst_s = 1'b0; en_s = 1'b1; mode_s = 2'd1;
    run_to_frame_start(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL timing_sync got=timeout exp=frame_start"); return; end
    since_fs = 0; fs_cnt = 0; de_run = 1; de_lines = 0; hs_run = 0; since_de_fall = 100;
    prev_de = 1'b1; prev_hs = 1'b1;
    for (int i = 0; i < 576; i++) begin
      drive_cycle();
      since_fs++;
      since_de_fall++;
      if (vid.DE) de_run++;
      else if (prev_de) begin
        checks++;
        if (de_run != 16) begin failures++; $display("FAIL de_width got=%0d exp=16", de_run); end
        de_run = 0; since_de_fall = 0; de_lines++;
      end
      if (!vid.HSYNC) begin
        hs_run++;
        if (prev_hs && since_de_fall < 24) begin
          checks++;
          if (since_de_fall != 2) begin failures++; $display("FAIL hs_delay got=%0d exp=2", since_de_fall); end
        end
      end else if (!prev_hs) begin
        checks++;
        if (hs_run != 3) begin failures++; $display("FAIL hs_width got=%0d exp=3", hs_run); end
        hs_run = 0;
      end
      if (vid.FRAME_START) begin
        fs_cnt++;
        checks++;
        if (since_fs != 288) begin failures++; $display("FAIL fs_period got=%0d exp=288", since_fs); end
        checks++;
        if (de_lines != 8) begin failures++; $display("FAIL de_lines got=%0d exp=8", de_lines); end
        since_fs = 0; de_lines = 0;
      end
      prev_de = vid.DE;
      prev_hs = vid.HSYNC;
    end
    checks++;
    if (fs_cnt != 2) begin failures++; $display("FAIL fs_count got=%0d exp=2", fs_cnt); end
  endtask

  task automatic test_vsync();
    bit ok;
    int since_fs, vs_run, falls;
    logic prev_vs;
    run_to_frame_start(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL vsync_sync got=timeout exp=frame_start"); return; end
    since_fs = 0; vs_run = 0; falls = 0; prev_vs = vid.VSYNC;
    for (int i = 0; i < 288; i++) begin
      drive_cycle();
      since_fs++;
      if (!vid.VSYNC) begin
        vs_run++;
        if (prev_vs) begin
          falls++;
          checks++;
          if (since_fs != 216) begin failures++; $display("FAIL vs_fall_pos got=%0d exp=216", since_fs); end
        end
      end else if (!prev_vs) begin
        checks++;
        if (since_fs != 264) begin failures++; $display("FAIL vs_rise_pos got=%0d exp=264", since_fs); end
        checks++;
        if (vs_run != 48) begin failures++; $display("FAIL vs_width got=%0d exp=48", vs_run); end
      end
      prev_vs = vid.VSYNC;
    end
    checks++;
    if (falls != 1) begin failures++; $display("FAIL vs_falls got=%0d exp=1", falls); end
  endtask

  task automatic test_bars();
    bit ok;
    int h, v;
    logic [23:0] exp_rgb;
    mode_s = 2'd1;
    run_to_frame_start(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bars_sync got=timeout exp=frame_start"); return; end
    checks++;
    if ({vid.RED, vid.GREEN, vid.BLUE} !== 24'hFFFFFF) begin failures++; $display("FAIL bars_px0 got=%h exp=FFFFFF", {vid.RED, vid.GREEN, vid.BLUE}); end
    for (int pos = 1; pos < 288; pos++) begin
      drive_cycle();
      h = pos % 24;
      v = pos / 24;
      exp_rgb = (h < 16 && v < 8) ? bar_colour(h / 2) : 24'h0;
      checks++;
      if ({vid.RED, vid.GREEN, vid.BLUE} !== exp_rgb) begin
        failures++;
        $display("FAIL bars_px h=%0d v=%0d got=%h exp=%h", h, v, {vid.RED, vid.GREEN, vid.BLUE}, exp_rgb);
      end
    end
  endtask

  task automatic test_mode_switch();
    bit ok;
    mode_s = 2'd0; solid_s = 24'h123456;
    run_to_frame_start(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL switch_sync got=timeout exp=frame_start"); return; end
    checks++;
    if ({vid.RED, vid.GREEN, vid.BLUE} !== 24'h123456) begin failures++; $display("FAIL solid_px0 got=%h exp=123456", {vid.RED, vid.GREEN, vid.BLUE}); end
    for (int i = 0; i < 100; i++) drive_cycle();
    mode_s = 2'd2; solid_s = 24'hABCDEF;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      drive_cycle();
      if (vid.FRAME_START === 1'b1) ok = 1'b1;
      else if (vid.DE === 1'b1) begin
        checks++;
        if ({vid.RED, vid.GREEN, vid.BLUE} !== 24'h123456) begin
          failures++;
          $display("FAIL solid_hold got=%h exp=123456", {vid.RED, vid.GREEN, vid.BLUE});
        end
      end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL switch_next_frame got=timeout exp=frame_start"); return; end
    checks++;
    if ({vid.RED, vid.GREEN, vid.BLUE} !== 24'h000000) begin failures++; $display("FAIL checker_0_0 got=%h exp=000000", {vid.RED, vid.GREEN, vid.BLUE}); end
    drive_cycle();
    drive_cycle();
    checks++;
    if ({vid.RED, vid.GREEN, vid.BLUE} !== 24'hFFFFFF) begin failures++; $display("FAIL checker_2_0 got=%h exp=FFFFFF", {vid.RED, vid.GREEN, vid.BLUE}); end
    for (int i = 0; i < 46; i++) drive_cycle();
    checks++;
    if ({vid.RED, vid.GREEN, vid.BLUE} !== 24'hFFFFFF) begin failures++; $display("FAIL checker_0_2 got=%h exp=FFFFFF", {vid.RED, vid.GREEN, vid.BLUE}); end
    drive_cycle();
    drive_cycle();
    checks++;
    if ({vid.DE, vid.RED, vid.GREEN, vid.BLUE} !== {1'b1, 24'h000000}) begin
      failures++;
      $display("FAIL checker_2_2 got=%b/%h exp=1/000000", vid.DE, {vid.RED, vid.GREEN, vid.BLUE});
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 400 && !(m_h == 5 && m_v == 3); i++) drive_cycle();
    checks++;
    if (!(m_h == 5 && m_v == 3)) begin failures++; $display("FAIL mid_reset_pos got=%0d,%0d exp=5,3", m_h, m_v); return; end
    checks++;
    if (vid.DE !== 1'b1) begin failures++; $display("FAIL pre_reset_de got=%b exp=1", vid.DE); end
    rst_s = 1'b1;
    drive_cycle();
    checks++;
    if ({vid.DE, vid.HSYNC, vid.VSYNC, vid.FRAME_START} !== 4'b0110) begin
      failures++;
      $display("FAIL mid_reset_ctrl got=%b exp=0110", {vid.DE, vid.HSYNC, vid.VSYNC, vid.FRAME_START});
    end
    checks++;
    if ({vid.RED, vid.GREEN, vid.BLUE} !== 24'h0) begin failures++; $display("FAIL mid_reset_rgb got=%h exp=000000", {vid.RED, vid.GREEN, vid.BLUE}); end
    rst_s = 1'b0;
    drive_cycle();
    checks++;
    if ({vid.FRAME_START, vid.DE} !== 2'b11) begin failures++; $display("FAIL restart_fs got=%b exp=11", {vid.FRAME_START, vid.DE}); end
  endtask

  task automatic test_gradient();
    bit ok;
    int h, v;
    logic [7:0] g;
    mode_s = 2'd3;
    run_to_frame_start(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL grad_sync got=timeout exp=frame_start"); return; end
    checks++;
    if ({vid.RED, vid.GREEN, vid.BLUE, vid.X, vid.Y} !== 31'h0) begin
      failures++;
      $display("FAIL grad_px0 got=%h x=%0d y=%0d exp=000000 x=0 y=0", {vid.RED, vid.GREEN, vid.BLUE}, vid.X, vid.Y);
    end
    for (int pos = 1; pos < 288; pos++) begin
      drive_cycle();
      h = pos % 24;
      v = pos / 24;
      g = (h < 16 && v < 8) ? 8'(h) : 8'h0;
      checks++;
      if ({vid.RED, vid.GREEN, vid.BLUE} !== {g, g, g}) begin
        failures++;
        $display("FAIL grad_px h=%0d v=%0d got=%h exp=%h", h, v, {vid.RED, vid.GREEN, vid.BLUE}, {g, g, g});
      end
      if (h < 16 && v < 8) begin
        checks++;
        if ({vid.X, vid.Y} !== {4'(h), 3'(v)}) begin
          failures++;
          $display("FAIL grad_xy got=%0d,%0d exp=%0d,%0d", vid.X, vid.Y, h, v);
        end
      end
    end
    en_s = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_cycle();
      checks++;
      if ({vid.DE, vid.HSYNC, vid.VSYNC, vid.FRAME_START, vid.RED, vid.GREEN, vid.BLUE} !== {4'b0110, 24'h0}) begin
        failures++;
        $display("FAIL en_low_idle got=%b%b%b%b/%h exp=0110/000000", vid.DE, vid.HSYNC, vid.VSYNC, vid.FRAME_START, {vid.RED, vid.GREEN, vid.BLUE});
      end
    end
    en_s = 1'b1;
    drive_cycle();
    checks++;
    if ({vid.FRAME_START, vid.DE, vid.X, vid.Y} !== {2'b11, 7'h0}) begin
      failures++;
      $display("FAIL en_restart got=fs%b de%b x%0d y%0d exp=fs1 de1 x0 y0", vid.FRAME_START, vid.DE, vid.X, vid.Y);
    end
    drive_cycle();
    checks++;
    if ({vid.X, vid.RED, vid.GREEN, vid.BLUE} !== {4'd1, 24'h010101}) begin
      failures++;
      $display("FAIL en_restart_x1 got=x%0d %h exp=x1 010101", vid.X, {vid.RED, vid.GREEN, vid.BLUE});
    end
  endtask

  initial begin
    rst = 1'b1; vid.EN = 1'b0; vid.MODE = 2'd0; vid.SOLID_RGB = 24'h0;
    rst_s = 1'b1; en_s = 1'b0; mode_s = 2'd0; solid_s = 24'h0;
    m_h = 0; m_v = 0; m_mode = 2'd0; m_solid = 24'h0;
    test_reset();
    test_timing();
    test_vsync();
    test_bars();
    test_mode_switch();
    test_mid_reset();
    test_gradient();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
